top2_frame_sequencer: RTL and testbench

- Frames an input sample stream into fixed-length groups and runs a largest/second-largest tracker over each frame.
- Clears the tracker at every frame start and emits one result per frame on a valid/ready output.
- Sits between a sample source and downstream statistics logic.
- Sequences the datapath: clear, accumulate, then hold the result until it is consumed.

---
 rtl/top2_frame_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_top2_frame_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top2_frame_sequencer.sv
// -----------------------------------------------------------------------------
// top2_frame_sequencer
//
// Purpose:
//   Splits an input sample stream into frames of cfg_len samples. For each
//   frame it finds the largest and second-largest sample, treating samples as
//   unsigned and counting duplicates. It emits one result per frame on a
//   valid/ready port.
//
//   The sequencer goes through three steps for each frame:
//     1. Clear the tracker.
//     2. Accumulate the samples of the frame.
//     3. Hold the result until downstream consumes it.
//
// Optional feature:
//   Define TOP2_SEQ_ABORT_EN to add the 'abort' input. Asserting abort during
//   accumulation discards the partial frame and returns to IDLE. No result is
//   emitted for that frame. If the macro is undefined, every frame runs to
//   completion.
//
// Ports:
//   clk       rising-edge clock
//   resetn    asynchronous active-low reset
//   en        run enable; sampled only at frame boundaries (IDLE / result handshake)
//   cfg_len   samples per frame, latched at frame start; 0 behaves as 1
//   s_valid   input sample valid
//   s_ready   block accepts a sample this cycle (high only while accumulating)
//   s_data    input sample
//   m_valid   frame result valid (high only while holding a result)
//   m_ready   downstream accepts the result
//   m_max     largest sample of the frame
//   m_second  second-largest sample of the frame
//   m_id      frame sequence number, wraps modulo 2^ID_W
//   abort     (TOP2_SEQ_ABORT_EN only) discard the frame being accumulated
//   busy      high while accumulating or holding a result
// -----------------------------------------------------------------------------
module top2_frame_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 8,
  parameter int ID_W       = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_max,
  output logic [DATA_WIDTH-1:0] m_second,
  output logic [ID_W-1:0]       m_id,
`ifdef TOP2_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Sample values are magnitudes, so every comparison is unsigned.
  function automatic logic [2*DATA_WIDTH-1:0] track_upd(
    input logic unsigned [DATA_WIDTH-1:0] d,
    input logic unsigned [DATA_WIDTH-1:0] mx,
    input logic unsigned [DATA_WIDTH-1:0] m2
  );
    // A sample equal to the current max falls to the second branch. That
    // branch is what lets a duplicate max become the second-largest value.
    if (d > mx) begin
      return {d, mx};
    end else if (d > m2) begin
      return {mx, d};
    end
    return {mx, m2};
  endfunction

  // A zero-length frame has no meaning, so it saturates to one sample.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

  state_t                        state_q;
  state_t                        state_d;
  logic                          start;
  logic                          clear;
  logic                          hs;
  logic                          abort_w;

  logic unsigned [DATA_WIDTH-1:0] max_q;
  logic unsigned [DATA_WIDTH-1:0] max2_q;
  logic [LEN_W-1:0]               cnt_q;
  logic [LEN_W-1:0]               len_q;

  logic                           acc_p0;
  logic                           last_p0;
  logic [2*DATA_WIDTH-1:0]        upd_p0;
  logic unsigned [DATA_WIDTH-1:0] upd_max_p0;
  logic unsigned [DATA_WIDTH-1:0] upd_sec_p0;

  logic unsigned [DATA_WIDTH-1:0] res_max_p1;
  logic unsigned [DATA_WIDTH-1:0] res_sec_p1;
  logic [ID_W-1:0]                id_p1;
  logic                           vld_p1;

`ifdef TOP2_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // ---- stage p0: sample acceptance and tracker update ----
  // An abort wins over a sample offered in the same cycle. That sample is
  // dropped even though s_ready is high.
  assign acc_p0     = s_valid && (state_q == ST_ACCUM) && !abort_w;
  assign last_p0    = acc_p0 && (cnt_q == (len_q - LEN_W'(1)));
  assign upd_p0     = track_upd(s_data, max_q, max2_q);
  assign upd_max_p0 = upd_p0[2*DATA_WIDTH-1:DATA_WIDTH];
  assign upd_sec_p0 = upd_p0[DATA_WIDTH-1:0];

  assign hs    = (state_q == ST_HOLD) && m_ready;
  assign clear = start || ((state_q == ST_ACCUM) && abort_w);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // 'start' marks a frame start. It fires from IDLE, or straight out of HOLD
  // on the result handshake, so back-to-back frames skip the IDLE bubble.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_ACCUM;
          start   = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (abort_w) begin
          state_d = ST_IDLE;
        end else if (last_p0) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (m_ready) begin
          state_d = en ? ST_ACCUM : ST_IDLE;
          start   = en;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      max_q  <= '0;
      max2_q <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
    end else begin
      if (clear) begin
        max_q  <= '0;
        max2_q <= '0;
        cnt_q  <= '0;
      end else if (acc_p0) begin
        max_q  <= upd_max_p0;
        max2_q <= upd_sec_p0;
        cnt_q  <= cnt_q + LEN_W'(1);
      end
      if (start) begin
        len_q <= clamp_len(cfg_len);
      end
    end
  end

  // ---- stage p1: registered frame result ----
  // The last sample is folded in on the way into the result registers. This
  // gives the result one cycle of latency after the final accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      res_max_p1 <= '0;
      res_sec_p1 <= '0;
      id_p1      <= '0;
    end else begin
      if (last_p0) begin
        res_max_p1 <= upd_max_p0;
        res_sec_p1 <= upd_sec_p0;
      end
      if (hs) begin
        id_p1 <= id_p1 + ID_W'(1);
      end
    end
  end

  assign vld_p1   = (state_q == ST_HOLD);

  assign s_ready  = (state_q == ST_ACCUM);
  assign m_valid  = vld_p1;
  assign m_max    = res_max_p1;
  assign m_second = res_sec_p1;
  assign m_id     = id_p1;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_top2_frame_sequencer.sv
module tb_top2_frame_sequencer;

  logic        clk;
  logic        resetn;
  logic        en;
  logic [7:0]  cfg_len;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_max;
  logic [31:0] m_second;
  logic [7:0]  m_id;
  logic        busy;
`ifdef TOP2_SEQ_ABORT_EN
  logic        abort;
`endif

  typedef struct packed {
    logic [31:0] mx;
    logic [31:0] sc;
    logic [7:0]  id;
  } res_t;

  res_t        sb[$];
  logic [31:0] smp[$];
  logic [7:0]  exp_id;
  int          n_checks;
  int          n_errors;

  logic        stalled;
  logic [31:0] st_max;
  logic [31:0] st_sec;
  logic [7:0]  st_id;

  top2_frame_sequencer #(
    .DATA_WIDTH(32),
    .LEN_W(8),
    .ID_W(8)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .en(en),
    .cfg_len(cfg_len),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data(s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_max(m_max),
    .m_second(m_second),
    .m_id(m_id),
`ifdef TOP2_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge. The sample is accepted at the first posedge where
  // s_ready is high. The task returns at the negedge after that accept.
  task automatic push_sample(input logic [31:0] d);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      check_eq("sready_timeout", s_ready, 1);
    end else begin
      @(negedge clk);
    end
  endtask

  // Runs one frame from smp[]. The expected result comes from a
  // "max, then max of the rest" reference and is pushed to the scoreboard.
  // drop_at: drop en after that many samples. stall: drop m_ready after the
  // first sample.
  task automatic run_frame(input logic [7:0] len, input int drop_at, input bit stall);
    res_t        r;
    int          im;
    logic [31:0] sc;
    cfg_len = len;
    im = 0;
    for (int i = 1; i < smp.size(); i++) if (smp[i] > smp[im]) im = i;
    sc = 0;
    for (int i = 0; i < smp.size(); i++) if (i != im && smp[i] > sc) sc = smp[i];
    r.mx = smp[im];
    r.sc = sc;
    r.id = exp_id;
    sb.push_back(r);
    exp_id = exp_id + 8'd1;
    for (int i = 0; i < smp.size(); i++) begin
      push_sample(smp[i]);
      if (i == 0 && stall) m_ready = 1'b0;
      if (i + 1 == drop_at) en = 1'b0;
    end
    s_valid = 1'b0;
    check_eq("lat_mvalid", m_valid, 1);
    check_eq("hold_sready", s_ready, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    exp_id = 8'd0;
    resetn = 1'b1;
  endtask

  // Monitor: pops the scoreboard on each result handshake and checks that a
  // stalled result stays unchanged.
  always begin
    @(negedge clk);
    #1;
    if (!resetn) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check_eq("stall_valid", m_valid, 1);
        check_eq("stall_max", m_max, st_max);
        check_eq("stall_sec", m_second, st_sec);
        check_eq("stall_id", m_id, st_id);
      end
      stalled = m_valid && !m_ready;
      st_max  = m_max;
      st_sec  = m_second;
      st_id   = m_id;
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_unexpected", m_valid, 0);
        end else begin
          res_t r;
          r = sb.pop_front();
          check_eq("res_max", m_max, r.mx);
          check_eq("res_sec", m_second, r.sc);
          check_eq("res_id", m_id, r.id);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    stalled  = 1'b0;
    exp_id   = 8'd0;
    resetn   = 1'b0;
    en       = 1'b0;
    cfg_len  = 8'd4;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b1;
`ifdef TOP2_SEQ_ABORT_EN
    abort    = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_sready", s_ready, 0);
    check_eq("rst_mvalid", m_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_max", m_max, 0);
    check_eq("rst_sec", m_second, 0);
    check_eq("rst_id", m_id, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_en0_busy", busy, 0);

    // Basic frame, then a duplicate max, then cfg_len=0 treated as 1.
    en = 1'b1;
    smp = '{32'd3, 32'd9, 32'd1, 32'd7};
    run_frame(8'd4, 0, 1'b0);
    smp = '{32'd5, 32'd5, 32'd2};
    run_frame(8'd3, 0, 1'b0);
    smp = '{32'hFFFF_FFFF};
    run_frame(8'd0, 0, 1'b0);

    // Stall the result for 5 cycles, then the next frame must start clean.
    smp = '{32'd10, 32'd40, 32'd30, 32'd20};
    run_frame(8'd4, 0, 1'b1);
    repeat (5) @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    check_eq("b2b_sready", s_ready, 1);
    smp = '{32'd2, 32'd1, 32'd1, 32'd0};
    run_frame(8'd4, 0, 1'b0);

    // en dropped mid-frame: the frame still completes, then the FSM idles.
    smp = '{32'd8, 32'd3, 32'd6, 32'd4};
    run_frame(8'd4, 2, 1'b0);
    @(negedge clk);
    check_eq("endrop_busy", busy, 0);
    check_eq("endrop_sready", s_ready, 0);
    repeat (2) @(negedge clk);
    check_eq("endrop_idle", s_ready, 0);

    // 256 single-sample frames: m_id wraps from 255 to 0.
    cfg_len = 8'd1;
    en = 1'b1;
    for (int f = 0; f < 256; f++) begin
      smp = '{$urandom()};
      run_frame(8'd1, 0, 1'b0);
    end
    en = 1'b0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of accumulation.
    cfg_len = 8'd4;
    en = 1'b1;
    push_sample(32'd100);
    push_sample(32'd200);
    s_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check_eq("arst_acc_sready", s_ready, 0);
    check_eq("arst_acc_busy", busy, 0);
    check_eq("arst_acc_mvalid", m_valid, 0);
    repeat (2) @(negedge clk);
    sb.delete();
    exp_id = 8'd0;
    resetn = 1'b1;
    smp = '{32'd4, 32'd4, 32'd4, 32'd1};
    run_frame(8'd4, 0, 1'b0);

    // Asynchronous reset while a result is held.
    smp = '{32'd7, 32'd6, 32'd5, 32'd9};
    run_frame(8'd4, 0, 1'b1);
    #3 resetn = 1'b0;
    #1;
    check_eq("arst_hold_mvalid", m_valid, 0);
    check_eq("arst_hold_sready", s_ready, 0);
    check_eq("arst_hold_max", m_max, 0);
    check_eq("arst_hold_sec", m_second, 0);
    check_eq("arst_hold_id", m_id, 0);
    repeat (2) @(negedge clk);
    sb.delete();
    exp_id = 8'd0;
    m_ready = 1'b1;
    resetn = 1'b1;
    smp = '{32'd1, 32'd1, 32'd1, 32'd2};
    run_frame(8'd4, 0, 1'b0);

`ifdef TOP2_SEQ_ABORT_EN
    // Abort after 2 of 4 samples, coincident with a valid sample.
    repeat (2) @(negedge clk);
    do_reset();
    cfg_len = 8'd4;
    en = 1'b1;
    push_sample(32'd50);
    push_sample(32'd60);
    s_valid = 1'b1;
    s_data  = 32'd99;
    abort   = 1'b1;
    @(negedge clk);
    abort   = 1'b0;
    s_valid = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_mvalid", m_valid, 0);
    smp = '{32'd1, 32'd2, 32'd3, 32'd4};
    run_frame(8'd4, 0, 1'b0);
`endif

    en = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
